// File: rtl/rvvi_ack_receiver.sv
// Parses host ACK frames from the Ethernet RX byte stream. Frames are filtered
// by destination MAC (local or broadcast) and EtherType. Each good ACK produces
// a one-cycle HostInstrValid pulse carrying the little-endian frame count.
// Bad, short or foreign frames are dropped and counted.
module rvvi_ack_receiver #(
  parameter int unsigned FRAME_COUNT_WIDTH = 16,
  parameter logic [15:0] ETHER_TYPE        = 16'h88B5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   RxData,
  input  logic                         RxValid,
  input  logic                         RxLast,
  input  logic                         RxError,
  input  logic [47:0]                  LocalMac,
  output logic                         HostInstrValid,
  output logic [FRAME_COUNT_WIDTH-1:0] HostFrameCount,
  output logic [31:0]                  AckCount,
  output logic [15:0]                  DropCount
);

  localparam int unsigned NumCountBytes = FRAME_COUNT_WIDTH / 8;
  localparam logic [3:0]  LastCountIdx  = 4'(NumCountBytes - 1);

  typedef enum logic [2:0] {
    StDst,
    StSrc,
    StType,
    StCount,
    StTail,
    StDrop
  } state_e;

  state_e                       r_state;
  logic [3:0]                   r_byte_idx;
  logic                         r_match_local;
  logic                         r_match_bcast;
  logic                         r_type_ok;
  logic [FRAME_COUNT_WIDTH-1:0] r_shadow;
  logic                         r_host_valid;
  logic [FRAME_COUNT_WIDTH-1:0] r_host_count;
  logic [31:0]                  r_ack_count;
  logic [15:0]                  r_drop_count;

  logic [7:0]                   w_mac_byte;
  logic [7:0]                   w_type_byte;
  logic [FRAME_COUNT_WIDTH-1:0] w_shadow_next;
  logic                         w_local_ok;
  logic                         w_bcast_ok;
  logic                         w_type_ok;
  logic                         w_accept;
  logic                         w_drop;

  // Per-byte compare values and running match flags; idx 0 restarts each flag.
  always_comb begin
    w_mac_byte    = 8'h00;
    w_shadow_next = r_shadow;
    for (int i = 0; i < 6; i++) begin
      if (r_byte_idx == 4'(i)) w_mac_byte = LocalMac[47-8*i -: 8];
    end
    if (r_state == StCount) begin
      for (int i = 0; i < int'(NumCountBytes); i++) begin
        if (r_byte_idx == 4'(i)) w_shadow_next[8*i +: 8] = RxData;
      end
    end
    w_type_byte = r_byte_idx[0] ? ETHER_TYPE[7:0] : ETHER_TYPE[15:8];
    w_local_ok  = ((r_byte_idx == 4'd0) || r_match_local) && (RxData == w_mac_byte);
    w_bcast_ok  = ((r_byte_idx == 4'd0) || r_match_bcast) && (RxData == 8'hFF);
    w_type_ok   = ((r_byte_idx == 4'd0) || r_type_ok) && (RxData == w_type_byte);
    w_accept    = RxValid && RxLast && !RxError &&
                  ((r_state == StTail) ||
                   ((r_state == StCount) && (r_byte_idx == LastCountIdx)));
    w_drop      = RxValid && RxLast && !w_accept;
  end

  // Frame parser FSM with registered outputs; idle beats hold all state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StDst;
      r_byte_idx    <= 4'd0;
      r_match_local <= 1'b0;
      r_match_bcast <= 1'b0;
      r_type_ok     <= 1'b0;
      r_shadow      <= '0;
      r_host_valid  <= 1'b0;
      r_host_count  <= '0;
      r_ack_count   <= 32'd0;
      r_drop_count  <= 16'd0;
    end else begin
      r_host_valid <= 1'b0;
      if (RxValid) begin
        r_shadow <= w_shadow_next;
        if (w_accept) begin
          r_host_valid <= 1'b1;
          r_host_count <= w_shadow_next;
          r_ack_count  <= r_ack_count + 32'd1;
        end
        if (w_drop && (r_drop_count != 16'hFFFF)) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
        if (RxLast) begin
          // Every frame end, good or bad, resynchronises to a new frame.
          r_state    <= StDst;
          r_byte_idx <= 4'd0;
        end else begin
          unique case (r_state)
            StDst: begin
              r_match_local <= w_local_ok;
              r_match_bcast <= w_bcast_ok;
              if (r_byte_idx == 4'd5) begin
                r_state    <= (w_local_ok || w_bcast_ok) ? StSrc : StDrop;
                r_byte_idx <= 4'd0;
              end else begin
                r_byte_idx <= r_byte_idx + 4'd1;
              end
            end
            StSrc: begin
              if (r_byte_idx == 4'd5) begin
                r_state    <= StType;
                r_byte_idx <= 4'd0;
              end else begin
                r_byte_idx <= r_byte_idx + 4'd1;
              end
            end
            StType: begin
              r_type_ok <= w_type_ok;
              if (r_byte_idx == 4'd1) begin
                r_state    <= w_type_ok ? StCount : StDrop;
                r_byte_idx <= 4'd0;
              end else begin
                r_byte_idx <= r_byte_idx + 4'd1;
              end
            end
            StCount: begin
              if (r_byte_idx == LastCountIdx) begin
                r_state    <= StTail;
                r_byte_idx <= 4'd0;
              end else begin
                r_byte_idx <= r_byte_idx + 4'd1;
              end
            end
            StTail, StDrop: begin
              r_byte_idx <= 4'd0;
            end
            default: begin
              r_state    <= StDst;
              r_byte_idx <= 4'd0;
            end
          endcase
        end
      end
    end
  end

  assign HostInstrValid = r_host_valid;
  assign HostFrameCount = r_host_count;
  assign AckCount       = r_ack_count;
  assign DropCount      = r_drop_count;

endmodule

// File: tb/tb_rvvi_ack_receiver.sv
// Directed bench for rvvi_ack_receiver: inputs change on the falling edge,
// outputs are sampled on the falling edge or just after it.
module tb_rvvi_ack_receiver;

  localparam logic [47:0] Mac   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] Bcast = 48'hFF_FF_FF_FF_FF_FF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  RxData = 8'h00;
  logic        RxValid = 1'b0;
  logic        RxLast = 1'b0;
  logic        RxError = 1'b0;
  logic [47:0] LocalMac = Mac;
  logic        HostInstrValid;
  logic [15:0] HostFrameCount;
  logic [31:0] AckCount;
  logic [15:0] DropCount;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          pulse_cnt = 0;
  int          pulse_cyc = -1;
  logic [15:0] pulse_q[$];
  logic [7:0]  frame_q[$];

  rvvi_ack_receiver #(
    .FRAME_COUNT_WIDTH(16),
    .ETHER_TYPE       (16'h88B5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .RxData        (RxData),
    .RxValid       (RxValid),
    .RxLast        (RxLast),
    .RxError       (RxError),
    .LocalMac      (LocalMac),
    .HostInstrValid(HostInstrValid),
    .HostFrameCount(HostFrameCount),
    .AckCount      (AckCount),
    .DropCount     (DropCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: each high sample is one cycle of HostInstrValid.
  always @(negedge clk) begin
    if (HostInstrValid === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
      pulse_q.push_back(HostFrameCount);
    end
  end

  task automatic drive_byte(input logic [7:0] d, input logic l, input logic e);
    @(negedge clk);
    RxData  = d;
    RxValid = 1'b1;
    RxLast  = l;
    RxError = e;
    if (l) last_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      RxValid = 1'b0;
      RxLast  = 1'b0;
      RxError = 1'b0;
    end
    #1;
  endtask

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype,
                             input int ncount, input logic [15:0] cnt, input int npad);
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(8'h0A + 8'(i));
    frame_q.push_back(etype[15:8]);
    frame_q.push_back(etype[7:0]);
    for (int i = 0; i < ncount; i++) frame_q.push_back(cnt[8*i +: 8]);
    for (int i = 0; i < npad; i++) frame_q.push_back(8'hA5 ^ 8'(i));
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype, input int ncount,
                            input logic [15:0] cnt, input int npad, input logic err,
                            input logic mid_err, input logic gaps);
    build_frame(dst, etype, ncount, cnt, npad);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps && (i > 0) && ($urandom_range(0, 2) == 0)) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          RxValid = 1'b0;
          RxLast  = 1'b0;
          RxData  = 8'hEE;
        end
      end
      if (i == frame_q.size() - 1) drive_byte(frame_q[i], 1'b1, err);
      else drive_byte(frame_q[i], 1'b0, mid_err);
    end
  endtask

  task automatic clear_mon();
    pulse_cnt = 0;
    pulse_cyc = -1;
    pulse_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    checks++;
    if (HostInstrValid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", HostInstrValid);
    end
    checks++;
    if (HostFrameCount !== 16'h0000) begin
      errors++; $display("FAIL reset_count: got %h want 0000", HostFrameCount);
    end
    checks++;
    if (AckCount !== 32'd0) begin
      errors++; $display("FAIL reset_ack: got %0d want 0", AckCount);
    end
    checks++;
    if (DropCount !== 16'd0) begin
      errors++; $display("FAIL reset_drop: got %0d want 0", DropCount);
    end
  endtask

  task automatic test_unicast();
    clear_mon();
    send_frame(Mac, 16'h88B5, 2, 16'h1234, 0, 1'b0, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (pulse_cnt !== 1) begin
      errors++; $display("FAIL uni_pulses: got %0d want 1", pulse_cnt);
    end
    checks++;
    if (pulse_cyc !== last_cyc) begin
      errors++; $display("FAIL uni_latency: pulse cycle %0d want %0d", pulse_cyc, last_cyc);
    end
    checks++;
    if (HostFrameCount !== 16'h1234) begin
      errors++; $display("FAIL uni_count: got %h want 1234", HostFrameCount);
    end
    checks++;
    if (AckCount !== 32'd1 || DropCount !== 16'd0) begin
      errors++; $display("FAIL uni_counters: ack %0d drop %0d want 1 0", AckCount, DropCount);
    end
  endtask

  task automatic test_broadcast();
    clear_mon();
    send_frame(Bcast, 16'h88B5, 2, 16'hBEEF, 10, 1'b0, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (pulse_cnt !== 1 || pulse_cyc !== last_cyc) begin
      errors++;
      $display("FAIL bcast_pulse: pulses %0d at %0d want 1 at %0d", pulse_cnt, pulse_cyc, last_cyc);
    end
    checks++;
    if (HostFrameCount !== 16'hBEEF || AckCount !== 32'd2) begin
      errors++; $display("FAIL bcast_count: got %h ack %0d want beef 2", HostFrameCount, AckCount);
    end
  endtask

  task automatic test_drops();
    clear_mon();
    send_frame(48'h02_00_00_00_00_02, 16'h88B5, 2, 16'h1111, 0, 1'b0, 1'b0, 1'b0);
    send_frame(Mac, 16'h0800, 2, 16'h2222, 0, 1'b0, 1'b0, 1'b0);
    send_frame(Mac, 16'h88B5, 1, 16'h3333, 0, 1'b0, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (pulse_cnt !== 0) begin
      errors++; $display("FAIL drop_pulses: got %0d want 0", pulse_cnt);
    end
    checks++;
    if (DropCount !== 16'd3) begin
      errors++; $display("FAIL drop_count: got %0d want 3", DropCount);
    end
    checks++;
    if (HostFrameCount !== 16'hBEEF || AckCount !== 32'd2) begin
      errors++; $display("FAIL drop_hold: got %h ack %0d want beef 2", HostFrameCount, AckCount);
    end
  endtask

  task automatic test_rx_error();
    clear_mon();
    send_frame(Mac, 16'h88B5, 2, 16'h5555, 3, 1'b1, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (pulse_cnt !== 0 || DropCount !== 16'd4) begin
      errors++; $display("FAIL err_last: pulses %0d drop %0d want 0 4", pulse_cnt, DropCount);
    end
    // Error on non-final beats must not matter.
    clear_mon();
    send_frame(Mac, 16'h88B5, 2, 16'h0042, 0, 1'b0, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (pulse_cnt !== 1 || HostFrameCount !== 16'h0042 || AckCount !== 32'd3) begin
      errors++;
      $display("FAIL err_mid: pulses %0d count %h ack %0d want 1 0042 3",
               pulse_cnt, HostFrameCount, AckCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got0;
    logic [15:0] got1;
    clear_mon();
    send_frame(Mac, 16'h88B5, 2, 16'h0005, 0, 1'b0, 1'b0, 1'b1);
    send_frame(Mac, 16'h88B5, 2, 16'h0006, 0, 1'b0, 1'b0, 1'b1);
    idle(4);
    got0 = (pulse_q.size() > 0) ? pulse_q[0] : 16'hxxxx;
    got1 = (pulse_q.size() > 1) ? pulse_q[1] : 16'hxxxx;
    checks++;
    if (pulse_cnt !== 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt);
    end
    checks++;
    if (got0 !== 16'h0005 || got1 !== 16'h0006) begin
      errors++; $display("FAIL b2b_counts: got %h %h want 0005 0006", got0, got1);
    end
    checks++;
    if (AckCount !== 32'd5 || DropCount !== 16'd4) begin
      errors++; $display("FAIL b2b_counters: ack %0d drop %0d want 5 4", AckCount, DropCount);
    end
  endtask

  task automatic test_one_byte();
    clear_mon();
    drive_byte(8'h02, 1'b1, 1'b0);
    send_frame(Mac, 16'h88B5, 2, 16'h0009, 0, 1'b0, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (DropCount !== 16'd5) begin
      errors++; $display("FAIL one_byte_drop: got %0d want 5", DropCount);
    end
    checks++;
    if (pulse_cnt !== 1 || HostFrameCount !== 16'h0009 || AckCount !== 32'd6) begin
      errors++;
      $display("FAIL one_byte_next: pulses %0d count %h ack %0d want 1 0009 6",
               pulse_cnt, HostFrameCount, AckCount);
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    build_frame(Mac, 16'h88B5, 2, 16'h4321, 0);
    for (int i = 0; i < 8; i++) drive_byte(frame_q[i], 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    RxData = frame_q[8];
    drive_byte(frame_q[9], 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (HostInstrValid !== 1'b0 || HostFrameCount !== 16'h0 || AckCount !== 32'd0 ||
        DropCount !== 16'd0) begin
      errors++;
      $display("FAIL midreset_clear: valid %b count %h ack %0d drop %0d want all 0",
               HostInstrValid, HostFrameCount, AckCount, DropCount);
    end
    for (int i = 10; i < frame_q.size(); i++) begin
      drive_byte(frame_q[i], (i == frame_q.size() - 1), 1'b0);
    end
    idle(4);
    checks++;
    if (pulse_cnt !== 0 || DropCount !== 16'd1 || AckCount !== 32'd0) begin
      errors++;
      $display("FAIL midreset_remnant: pulses %0d drop %0d ack %0d want 0 1 0",
               pulse_cnt, DropCount, AckCount);
    end
    send_frame(Mac, 16'h88B5, 2, 16'h7777, 0, 1'b0, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (pulse_cnt !== 1 || HostFrameCount !== 16'h7777 || AckCount !== 32'd1) begin
      errors++;
      $display("FAIL midreset_next: pulses %0d count %h ack %0d want 1 7777 1",
               pulse_cnt, HostFrameCount, AckCount);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_drops();
    test_rx_error();
    test_back_to_back();
    test_one_byte();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
